// File: rtl/anc_pkg.sv
// Shared definitions for the ANC receive phase scheduler: widths, reset
// defaults, the scheduler state encoding and a small step-size helper.
package anc_pkg;

  localparam int ANC_PHASE_WIDTH  = 24;
  localparam int ANC_CNT_WIDTH    = 24;
  localparam int ANC_PPM_WIDTH    = 32;
  localparam int ANC_NSWEEP_WIDTH = 16;

  localparam int unsigned DEF_NSIG       = 32'd32768;
  localparam int unsigned DEF_DPH_INC    = 32'd2048;
  localparam int unsigned DEF_START_PH   = 32'd0;
  localparam int unsigned DEF_PPM_PERIOD = 32'd868393;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } anc_state_e;

  // Index advance for one beat: a drift-correction beat skips one sample.
  function automatic logic [1:0] step_size(input logic step2);
    return step2 ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/anc_ppm_step.sv
// Drift-correction beat counter: flags every period-th accepted beat as a
// double step. The count runs across sweep boundaries and restarts only on clr.
module anc_ppm_step
  import anc_pkg::*;
#(
  parameter int PPM_WIDTH = ANC_PPM_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [PPM_WIDTH-1:0] period,
  output logic                 step2
);

  logic [PPM_WIDTH-1:0] cnt_r;

  // A period of zero never matches, which disables correction.
  assign step2 = (period != '0) && (cnt_r == period);

  // Beat counter: restarts at 1 on run start and after each double step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= PPM_WIDTH'(1);
    end else if (clr) begin
      cnt_r <= PPM_WIDTH'(1);
    end else if (adv) begin
      cnt_r <= step2 ? PPM_WIDTH'(1) : cnt_r + PPM_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/anc_phase_sched.sv
// Phase-stream scheduler for the ANC frequency shifter: emits stepped phases for
// n = 1..nsig on an AXI stream, counts sweeps and handles start/abort/bounded runs.
module anc_phase_sched
  import anc_pkg::*;
#(
  parameter int          PHASE_WIDTH    = ANC_PHASE_WIDTH,
  parameter int          CNT_WIDTH      = ANC_CNT_WIDTH,
  parameter int          PPM_WIDTH      = ANC_PPM_WIDTH,
  parameter int          NSWEEP_WIDTH   = ANC_NSWEEP_WIDTH,
  parameter int unsigned DEF_NSIG       = anc_pkg::DEF_NSIG,
  parameter int unsigned DEF_DPH_INC    = anc_pkg::DEF_DPH_INC,
  parameter int unsigned DEF_START_PH   = anc_pkg::DEF_START_PH,
  parameter int unsigned DEF_PPM_PERIOD = anc_pkg::DEF_PPM_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_WIDTH-1:0]    cfg_nsig,
  input  logic [PHASE_WIDTH-1:0]  cfg_dph_inc,
  input  logic [PHASE_WIDTH-1:0]  cfg_start_ph,
  input  logic [PPM_WIDTH-1:0]    cfg_ppm_period,
  input  logic [NSWEEP_WIDTH-1:0] cfg_nsweeps,
  input  logic                    cfg_load,
  input  logic                    start,
  input  logic                    abort,
  output logic [PHASE_WIDTH-1:0]  phase_tdata,
  output logic                    phase_tvalid,
  output logic                    phase_tlast,
  input  logic                    phase_tready,
  output logic [CNT_WIDTH-1:0]    sample_idx,
  output logic [NSWEEP_WIDTH-1:0] sweep_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  anc_state_e              state_r;
  logic [CNT_WIDTH-1:0]    nsig_r;
  logic [PHASE_WIDTH-1:0]  dph_inc_r;
  logic [PHASE_WIDTH-1:0]  start_ph_r;
  logic [PPM_WIDTH-1:0]    ppm_period_r;
  logic [NSWEEP_WIDTH-1:0] nsweeps_r;

  logic [CNT_WIDTH-1:0]    n_r;
  logic [PHASE_WIDTH-1:0]  phase_r;
  logic [NSWEEP_WIDTH-1:0] sweep_cnt_r;
  logic                    tvalid_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    cfg_err_r;
  logic                    abort_r;

  logic                    step2_s;
  logic                    hs_s;
  logic                    ppm_clr_s;
  logic [CNT_WIDTH-1:0]    nsig_eff_s;
  logic [CNT_WIDTH:0]      n_step_s;
  logic                    last_norm_s;
  logic [PHASE_WIDTH-1:0]  phase_inc_s;
  logic [NSWEEP_WIDTH-1:0] sweep_inc_s;
  logic                    run_end_s;

  anc_ppm_step #(
    .PPM_WIDTH (PPM_WIDTH)
  ) u_ppm_step (
    .clk    (clk),
    .reset  (reset),
    .clr    (ppm_clr_s),
    .adv    (hs_s),
    .period (ppm_period_r),
    .step2  (step2_s)
  );

  // Beat decode from registered n, ppm count and nsig; nsig of 0 behaves as 1.
  always_comb begin
    hs_s        = tvalid_r && phase_tready;
    ppm_clr_s   = (state_r == ST_IDLE) && start;
    nsig_eff_s  = (nsig_r == '0) ? CNT_WIDTH'(1) : nsig_r;
    n_step_s    = {1'b0, n_r} + (CNT_WIDTH + 1)'(step_size(step2_s));
    last_norm_s = n_step_s > {1'b0, nsig_eff_s};
    phase_inc_s = step2_s ? {dph_inc_r[PHASE_WIDTH-2:0], 1'b0} : dph_inc_r;
    sweep_inc_s = (sweep_cnt_r == '1) ? sweep_cnt_r : sweep_cnt_r + NSWEEP_WIDTH'(1);
    run_end_s   = (nsweeps_r != '0) &&
                  (({1'b0, sweep_cnt_r} + (NSWEEP_WIDTH + 1)'(1)) == {1'b0, nsweeps_r});
  end

  assign phase_tdata  = phase_r;
  assign phase_tvalid = tvalid_r;
  assign phase_tlast  = tvalid_r && (last_norm_s || abort_r);
  assign sample_idx   = n_r;
  assign sweep_cnt    = sweep_cnt_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign cfg_err      = cfg_err_r;

  // Scheduler FSM with config capture, index/phase accumulators and sweep count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      nsig_r       <= CNT_WIDTH'(DEF_NSIG);
      dph_inc_r    <= PHASE_WIDTH'(DEF_DPH_INC);
      start_ph_r   <= PHASE_WIDTH'(DEF_START_PH);
      ppm_period_r <= PPM_WIDTH'(DEF_PPM_PERIOD);
      nsweeps_r    <= '0;
      n_r          <= '0;
      phase_r      <= '0;
      sweep_cnt_r  <= '0;
      tvalid_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cfg_err_r    <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      cfg_err_r <= cfg_load && (state_r != ST_IDLE);
      done_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_load) begin
            nsig_r       <= cfg_nsig;
            dph_inc_r    <= cfg_dph_inc;
            start_ph_r   <= cfg_start_ph;
            ppm_period_r <= cfg_ppm_period;
            nsweeps_r    <= cfg_nsweeps;
          end
          if (start) begin
            state_r     <= ST_RUN;
            tvalid_r    <= 1'b1;
            busy_r      <= 1'b1;
            n_r         <= CNT_WIDTH'(1);
            phase_r     <= cfg_load ? cfg_start_ph : start_ph_r;
            sweep_cnt_r <= '0;
            abort_r     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            abort_r <= 1'b1;
          end
          if (hs_s) begin
            if (last_norm_s) begin
              n_r         <= CNT_WIDTH'(1);
              phase_r     <= start_ph_r;
              sweep_cnt_r <= sweep_inc_s;
            end else begin
              n_r     <= n_step_s[CNT_WIDTH-1:0];
              phase_r <= phase_r + phase_inc_s;
            end
            // An abort already latched makes this accepted beat the final one.
            if (abort_r || (last_norm_s && run_end_s)) begin
              state_r  <= ST_FIN;
              tvalid_r <= 1'b0;
              done_r   <= 1'b1;
              abort_r  <= 1'b0;
            end
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
          busy_r   <= 1'b0;
          abort_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anc_phase_sched.sv
// Self-checking bench for anc_phase_sched: directed table, randomized runs
// against a sweep-level reference model, and hand sequences for abort/guard/reset.
module tb_anc_phase_sched;

  localparam int PW = 24;
  localparam int CW = 24;
  localparam int QW = 32;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] cfg_nsig;
  logic [PW-1:0] cfg_dph_inc;
  logic [PW-1:0] cfg_start_ph;
  logic [QW-1:0] cfg_ppm_period;
  logic [SW-1:0] cfg_nsweeps;
  logic          cfg_load;
  logic          start;
  logic          abort;
  logic [PW-1:0] phase_tdata;
  logic          phase_tvalid;
  logic          phase_tlast;
  logic          phase_tready;
  logic [CW-1:0] sample_idx;
  logic [SW-1:0] sweep_cnt;
  logic          busy;
  logic          done;
  logic          cfg_err;

  always #5 clk = ~clk;

  anc_phase_sched dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_nsig       (cfg_nsig),
    .cfg_dph_inc    (cfg_dph_inc),
    .cfg_start_ph   (cfg_start_ph),
    .cfg_ppm_period (cfg_ppm_period),
    .cfg_nsweeps    (cfg_nsweeps),
    .cfg_load       (cfg_load),
    .start          (start),
    .abort          (abort),
    .phase_tdata    (phase_tdata),
    .phase_tvalid   (phase_tvalid),
    .phase_tlast    (phase_tlast),
    .phase_tready   (phase_tready),
    .sample_idx     (sample_idx),
    .sweep_cnt      (sweep_cnt),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  typedef struct {
    logic [CW-1:0] nsig;
    logic [PW-1:0] inc;
    logic [PW-1:0] st;
    logic [QW-1:0] ppm;
    logic [SW-1:0] nsw;
  } cfg_t;

  typedef struct {
    logic [PW-1:0] ph;
    logic [CW-1:0] idx;
    logic          last;
    logic [SW-1:0] sw;
  } beat_t;

  typedef struct {
    cfg_t          c;
    int            beats;
    logic [PW-1:0] lph;
    logic [CW-1:0] lidx;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic cfg_t mk_cfg(input int unsigned nsig, input int unsigned inc, input int unsigned st,
                                  input int unsigned ppm, input int unsigned nsw);
    cfg_t c;
    c.nsig = CW'(nsig);
    c.inc  = PW'(inc);
    c.st   = PW'(st);
    c.ppm  = QW'(ppm);
    c.nsw  = SW'(nsw);
    return c;
  endfunction

  // Reference: beat k of the run (from 1) is a double step when k is a multiple
  // of ppm; the phase of sample n is start + (n-1)*inc modulo 2^24.
  function automatic void build_model(input cfg_t c, input int max_beats);
    longint nsig_e, n, k, step, sweeps;
    beat_t  b;
    exp_q.delete();
    nsig_e = (c.nsig == '0) ? 1 : longint'(c.nsig);
    n = 1;
    sweeps = 0;
    for (k = 1; k <= max_beats; k++) begin
      step   = (c.ppm != '0 && (k % longint'(c.ppm)) == 0) ? 2 : 1;
      b.ph   = PW'((longint'(c.st) + (n - 1) * longint'(c.inc)) & 64'hFFFFFF);
      b.idx  = CW'(n);
      b.last = (n + step > nsig_e);
      b.sw   = SW'(sweeps);
      exp_q.push_back(b);
      if (b.last) begin
        sweeps++;
        n = 1;
        if (c.nsw != '0 && sweeps == longint'(c.nsw)) break;
      end else begin
        n = n + step;
      end
    end
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_nsig       = c.nsig;
    cfg_dph_inc    = c.inc;
    cfg_start_ph   = c.st;
    cfg_ppm_period = c.ppm;
    cfg_nsweeps    = c.nsw;
  endtask

  // Loads the config (separately or together with start), then runs to done
  // while checking every presented beat against the model front entry.
  task automatic run_case(input cfg_t c, input int stall_pct, input bit same_cycle,
                          output int nb, output int mn, output logic [PW-1:0] lph,
                          output logic [CW-1:0] lidx, output logic [SW-1:0] lsw);
    bit    fin;
    beat_t b;
    build_model(c, 5000);
    mn = exp_q.size();
    nb = 0; lph = '0; lidx = '0; lsw = '0; fin = 1'b0;
    drive_cfg(c);
    if (!same_cycle) begin
      cfg_load = 1'b1;
      @(posedge clk); #1;
      cfg_load = 1'b0;
    end else begin
      cfg_load = 1'b1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_load = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      phase_tready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (cyc == 0) chk("tvalid_after_start", phase_tvalid, 1);
      if (done) begin
        fin = 1'b1;
        chk("beats_left_at_done", exp_q.size(), 0);
        chk("tvalid_in_fin", phase_tvalid, 0);
        chk("busy_in_fin", busy, 1);
        lsw = sweep_cnt;
      end else if (phase_tvalid) begin
        if (exp_q.size() == 0) begin
          fail("extra_beat");
        end else begin
          b = exp_q[0];
          chk("beat_data_idx", {phase_tdata, sample_idx}, {b.ph, b.idx});
          chk("beat_last_sweep", {phase_tlast, sweep_cnt}, {b.last, b.sw});
          if (phase_tready) begin
            nb++;
            lph  = phase_tdata;
            lidx = sample_idx;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("tvalid_in_run", phase_tvalid, 1);
      end
      @(posedge clk); #1;
    end
    if (!fin) fail("run_timeout");
    phase_tready = 1'b0;
    @(negedge clk);
    chk("busy_after_fin", busy, 0);
    chk("done_one_cycle", done, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_stream"}, {phase_tvalid, phase_tlast, phase_tdata, sample_idx}, 0);
    chk({tag, "_status"}, {sweep_cnt, busy, done, cfg_err}, 0);
  endtask

  vec_t          vt[7];
  int            nb, mn;
  logic [PW-1:0] lph;
  logic [CW-1:0] lidx;
  logic [SW-1:0] lsw;
  cfg_t          c;

  initial begin
    reset = 1'b1; cfg_load = 1'b0; start = 1'b0; abort = 1'b0; phase_tready = 1'b0;
    drive_cfg(mk_cfg(0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table: config plus hand-derived beat count and final beat.
    vt[0] = '{c: mk_cfg(4, 16, 0, 0, 2),                  beats: 8,  lph: 24'd48,      lidx: 24'd4};
    vt[1] = '{c: mk_cfg(8, 16, 0, 3, 2),                  beats: 12, lph: 24'd96,      lidx: 24'd7};
    vt[2] = '{c: mk_cfg(3, 5, 100, 0, 2),                 beats: 6,  lph: 24'd110,     lidx: 24'd3};
    vt[3] = '{c: mk_cfg(0, 7, 9, 0, 3),                   beats: 3,  lph: 24'd9,       lidx: 24'd1};
    vt[4] = '{c: mk_cfg(3, 24'h800000, 24'hC00000, 0, 1), beats: 3,  lph: 24'hC00000,  lidx: 24'd3};
    vt[5] = '{c: mk_cfg(5, 1, 0, 1, 1),                   beats: 3,  lph: 24'd4,       lidx: 24'd5};
    vt[6] = '{c: mk_cfg(4, 10, 0, 2, 2),                  beats: 6,  lph: 24'd30,      lidx: 24'd4};
    for (int i = 0; i < 7; i++) begin
      run_case(vt[i].c, (i % 2) * 40, (i == 2), nb, mn, lph, lidx, lsw);
      chk("tbl_beats", nb, vt[i].beats);
      chk("tbl_last_phase", lph, vt[i].lph);
      chk("tbl_last_idx", lidx, vt[i].lidx);
      chk("tbl_sweeps", lsw, vt[i].c.nsw);
    end

    // Same sweep under heavy backpressure must give the same beat sequence.
    run_case(vt[1].c, 60, 1'b0, nb, mn, lph, lidx, lsw);
    chk("bp_beats", nb, vt[1].beats);

    // Randomized bounded runs against the model.
    for (int r = 0; r < 14; r++) begin
      c = mk_cfg($urandom_range(6), $urandom() & 32'hFFFFFF, $urandom() & 32'hFFFFFF,
                 $urandom_range(4), $urandom_range(3, 1));
      run_case(c, ($urandom_range(1) == 0) ? 0 : 45, $urandom_range(1) == 1, nb, mn, lph, lidx, lsw);
      chk("rnd_beats", nb, mn);
      chk("rnd_sweeps", lsw, c.nsw);
    end

    // Abort on the 2nd beat while stalled: beat held, forced last, then done.
    drive_cfg(mk_cfg(100, 16, 0, 0, 0));
    cfg_load = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; start = 1'b0; phase_tready = 1'b1;
    @(negedge clk);
    chk("ab_beat1", {phase_tvalid, phase_tlast, phase_tdata, sample_idx}, {2'b10, 24'd0, 24'd1});
    @(posedge clk); #1;
    phase_tready = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk("ab_beat2_pre", {phase_tvalid, phase_tlast, phase_tdata, sample_idx}, {2'b10, 24'd16, 24'd2});
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_beat2_forced", {phase_tvalid, phase_tlast, phase_tdata, sample_idx}, {2'b11, 24'd16, 24'd2});
    @(posedge clk); #1;
    phase_tready = 1'b1;
    @(negedge clk);
    chk("ab_beat2_send", {phase_tvalid, phase_tlast, sample_idx}, {2'b11, 24'd2});
    @(posedge clk); #1;
    phase_tready = 1'b0;
    @(negedge clk);
    chk("ab_fin", {done, phase_tvalid, busy, sweep_cnt}, {3'b101, 16'd0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_idle", {done, busy}, 2'b00);
    @(posedge clk); #1;

    // Config load during a run is rejected and flagged; stream unaffected.
    drive_cfg(mk_cfg(4, 16, 0, 0, 0));
    cfg_load = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; start = 1'b0; phase_tready = 1'b1;
    drive_cfg(mk_cfg(2, 1, 5, 1, 1));
    for (int k = 1; k <= 10; k++) begin
      cfg_load = (k == 3);
      @(negedge clk);
      chk("guard_beat", {phase_tdata, sample_idx},
          {PW'(16 * ((k - 1) % 4)), CW'(((k - 1) % 4) + 1)});
      chk("guard_last_sweep", {phase_tlast, sweep_cnt}, {((k % 4) == 0), SW'((k - 1) / 4)});
      chk("guard_cfg_err", cfg_err, (k == 4));
      @(posedge clk); #1;
    end
    cfg_load = 1'b0;

    // Mid-run reset: everything back to zero, config back to defaults.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle_zero("midrun_reset");
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("default_beat", {phase_tvalid, phase_tlast, phase_tdata, sample_idx},
          {2'b10, PW'(2048 * (k - 1)), CW'(k)});
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle_zero("final_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
